// File: rtl/jk_bank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : jk_seq_pkg
// Description : Shared opcode encodings, FSM state type and the JK next-state
//               helper for the JK bank sequencer.
// Contents    : OP_HOLD/OP_CLR/OP_SET/OP_TOG  {j,k} opcode constants
//               state_t                       sequencer FSM states
//               jk_next()                     next Q of a JK cell
// Revision    : 1.0  initial release
// ============================================================================
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // Next Q of a JK flip-flop given its current Q and the {j,k} pair.
  function automatic logic jk_next(input logic q, input logic [1:0] op);
    logic nq;
    case (op)
      OP_HOLD: nq = q;
      OP_CLR:  nq = 1'b0;
      OP_SET:  nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : jk_bank_sequencer_if
// Description : Requester command bus plus bank/completion status of the JK
//               bank sequencer.
// Signals     : req_valid/req_op/req_idx  requester -> sequencer commands
//               req_ready                 one-hot grant strobe
//               bank_q                    live Q of every cell
//               busy, done_*              sequencer status and completion
// Modports    : master (control logic side), slave (sequencer side)
// Revision    : 1.0  initial release
// ============================================================================
interface jk_bank_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [IDX_W*NUM_REQ-1:0] req_idx;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         bank_q;
  logic                     busy;
  logic                     done_valid;
  logic [ID_W-1:0]          done_id;
  logic                     done_q;
  logic                     done_err;

  modport master (
    output req_valid, req_op, req_idx,
    input  req_ready, bank_q, busy, done_valid, done_id, done_q, done_err
  );

  modport slave (
    input  req_valid, req_op, req_idx,
    output req_ready, bank_q, busy, done_valid, done_id, done_q, done_err
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_sequencer_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single positive-edge JK flip-flop with synchronous,
//               active-high reset.
// Ports       : clk    clock, rising edge
//               reset  synchronous active-high reset (Q -> 0)
//               j_i    J input
//               k_i    K input
//               q_o    registered Q
// Revision    : 1.0  initial release
// ============================================================================
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= jk_next(q_q, {j_i, k_i});
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_sequencer
// Description : Shares a bank of WIDTH JK cells among NUM_REQ requesters.
//               Round-robin arbitration accepts one {j,k}/index command per
//               three cycles (IDLE -> APPLY -> REPORT), pulses the addressed
//               cell for one cycle and reports the resulting Q.
// Ports       : clk    clock, rising edge
//               reset  synchronous active-high reset
//               bus    jk_bank_sequencer_if.slave (requests, grant, bank
//                      state, busy and completion report)
// Revision    : 1.0  initial release
// ============================================================================
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  jk_bank_sequencer_if.slave   bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ID_W-1:0]   id_q;
  logic              done_valid_q;
  logic [ID_W-1:0]   done_id_q;
  logic              done_q_q;
  logic              done_err_q;

  logic [WIDTH-1:0]  bank;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: scan offsets 0..NUM_REQ-1 from ptr and take the
  // first valid requester. The offset loop gives the rotation; the
  // "!arb_found" guard is the priority encoder.
  // --------------------------------------------------------------------------
  logic               arb_found;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  logic [1:0]         arb_op;
  logic [IDX_W-1:0]   arb_idx;
  logic [ID_W-1:0]    ptr_d;

  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    arb_id    = '0;
    arb_op    = OP_HOLD;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!arb_found && bus.req_valid[r] &&
            (((int'(ptr_q) + i) % NUM_REQ) == r)) begin
          arb_found    = 1'b1;
          arb_grant[r] = 1'b1;
          arb_id       = ID_W'(r);
          arb_op       = bus.req_op[2*r +: 2];
          arb_idx      = bus.req_idx[IDX_W*r +: IDX_W];
        end
      end
    end
  end

  assign ptr_d = ID_W'((int'(arb_id) + 1) % NUM_REQ);

  // Grant only while idle and out of reset; the requester sees it in the
  // same cycle it presents the command.
  assign bus.req_ready = (state_q == S_IDLE && !reset) ? arb_grant : '0;

  // --------------------------------------------------------------------------
  // Cell decode. An out-of-range index matches no cell, so nothing is
  // pulsed and idx_in_range flags the error for the report.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] cell_sel;
  logic             idx_in_range;
  logic             cur_q;

  generate
    for (genvar w = 0; w < WIDTH; w++) begin : g_cell
      logic pulse;
      assign cell_sel[w] = (idx_q == IDX_W'(w));
      assign pulse       = (state_q == S_APPLY) && cell_sel[w];

      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j_i   (pulse & op_q[1]),
        .k_i   (pulse & op_q[0]),
        .q_o   (bank[w])
      );
    end
  endgenerate

  assign idx_in_range = |cell_sel;
  assign cur_q        = |(bank & cell_sel);

  // --------------------------------------------------------------------------
  // Sequencer FSM. The completion Q is computed on the APPLY edge from the
  // same pre-update value the cell sees, so it equals the cell's new Q.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      op_q         <= OP_HOLD;
      idx_q        <= '0;
      id_q         <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_q_q     <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_valid_q <= 1'b0;
          done_id_q    <= '0;
          done_q_q     <= 1'b0;
          done_err_q   <= 1'b0;
          if (arb_found) begin
            op_q    <= arb_op;
            idx_q   <= arb_idx;
            id_q    <= arb_id;
            ptr_q   <= ptr_d;
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          done_valid_q <= 1'b1;
          done_id_q    <= id_q;
          done_q_q     <= idx_in_range ? jk_next(cur_q, op_q) : 1'b0;
          done_err_q   <= !idx_in_range;
          state_q      <= S_REPORT;
        end
        S_REPORT: begin
          done_valid_q <= 1'b0;
          done_id_q    <= '0;
          done_q_q     <= 1'b0;
          done_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          done_valid_q <= 1'b0;
          done_id_q    <= '0;
          done_q_q     <= 1'b0;
          done_err_q   <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bank_q     = bank;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_q     = done_q_q;
  assign bus.done_err   = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_sequencer
// Description : Directed self-checking bench for jk_bank_sequencer
//               (NUM_REQ=4, WIDTH=8, IDX_W=4 so index 8 is expressible).
// Revision    : 1.0  initial release
// ============================================================================
module tb_jk_bank_sequencer;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDX_W   = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  jk_bank_sequencer_if #(
    .NUM_REQ (NUM_REQ), .WIDTH (WIDTH), .IDX_W (IDX_W), .ID_W (ID_W)
  ) bus ();

  jk_bank_sequencer #(
    .NUM_REQ (NUM_REQ), .WIDTH (WIDTH), .IDX_W (IDX_W), .ID_W (ID_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1-2 time units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [IDX_W-1:0] idx);
    bus.req_valid[r]             = 1'b1;
    bus.req_op[2*r +: 2]         = op;
    bus.req_idx[IDX_W*r +: IDX_W] = idx;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_idx   = '0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_op    = 8'b11_10_01_11;
    bus.req_idx   = 16'h3210;
    tick();
    tick();
    #1;
    tests++; if (bus.bank_q !== 8'h00) begin fails++; $display("FAIL reset_bank: got %h want 00", bus.bank_q); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done_valid !== 1'b0 || bus.done_q !== 1'b0 || bus.done_err !== 1'b0) begin
      fails++; $display("FAIL reset_done: got v=%b q=%b e=%b want 0 0 0", bus.done_valid, bus.done_q, bus.done_err);
    end
    clear_reqs();
    reset = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    set_req(0, 2'b10, 4'd5);
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
    tick();  // grant edge -> APPLY
    clear_reqs();
    #1;
    tests++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0000 || bus.bank_q !== 8'h00 || bus.done_valid !== 1'b0) begin
      fails++; $display("FAIL single_apply: got busy=%b ready=%b bank=%h dv=%b want 1 0000 00 0",
                        bus.busy, bus.req_ready, bus.bank_q, bus.done_valid);
    end
    tick();  // APPLY edge -> REPORT
    #1;
    tests++; if (bus.bank_q !== 8'h20) begin fails++; $display("FAIL single_bank: got %h want 20", bus.bank_q); end
    tests++; if (bus.done_valid !== 1'b1 || bus.done_id !== 2'd0 || bus.done_q !== 1'b1 || bus.done_err !== 1'b0) begin
      fails++; $display("FAIL single_done: got v=%b id=%0d q=%b e=%b want 1 0 1 0",
                        bus.done_valid, bus.done_id, bus.done_q, bus.done_err);
    end
    tick();  // back to IDLE
    #1;
    tests++; if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL single_idle: got dv=%b busy=%b want 0 0", bus.done_valid, bus.busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [7:0] exp_bank [5];
    logic       exp_q    [5];
    logic [3:0] exp_grant;
    exp_bank = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    exp_q    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 2'b11, IDX_W'(r));
    for (int k = 0; k < 5; k++) begin
      exp_grant = 4'b0001 << (k % 4);
      #1;
      tests++; if (bus.req_ready !== exp_grant) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, exp_grant);
      end
      tick();  // APPLY
      #1;
      tests++; if (bus.req_ready !== 4'b0000) begin
        fails++; $display("FAIL rr_ready_busy[%0d]: got %b want 0000", k, bus.req_ready);
      end
      tick();  // REPORT
      #1;
      tests++; if (bus.bank_q !== exp_bank[k]) begin
        fails++; $display("FAIL rr_bank[%0d]: got %h want %h", k, bus.bank_q, exp_bank[k]);
      end
      tests++; if (bus.done_valid !== 1'b1 || bus.done_id !== ID_W'(k % 4) || bus.done_q !== exp_q[k]) begin
        fails++; $display("FAIL rr_done[%0d]: got v=%b id=%0d q=%b want 1 %0d %b",
                          k, bus.done_valid, bus.done_id, bus.done_q, k % 4, exp_q[k]);
      end
      tick();  // IDLE
    end
    clear_reqs();
  endtask

  // --------------------------------------------------------------------------
  // Starts with ptr=1, bank=0E.
  task automatic test_toggle_twice();
    logic exp_v [2];
    exp_v = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      set_req(2, 2'b11, 4'd7);
      #1;
      tests++; if (bus.req_ready !== 4'b0100) begin
        fails++; $display("FAIL tog_grant[%0d]: got %b want 0100", k, bus.req_ready);
      end
      tick();
      clear_reqs();
      tick();
      #1;
      tests++; if (bus.bank_q[7] !== exp_v[k] || bus.bank_q[6:0] !== 7'h0E) begin
        fails++; $display("FAIL tog_bank[%0d]: got %h want %h", k, bus.bank_q, {exp_v[k], 7'h0E});
      end
      tests++; if (bus.done_valid !== 1'b1 || bus.done_id !== 2'd2 || bus.done_q !== exp_v[k]) begin
        fails++; $display("FAIL tog_done[%0d]: got v=%b id=%0d q=%b want 1 2 %b",
                          k, bus.done_valid, bus.done_id, bus.done_q, exp_v[k]);
      end
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  // Starts with ptr=3, bank=0E. r1 wins by wrap-around, ptr must become 2.
  task automatic test_error();
    set_req(1, 2'b10, 4'd8);
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL err_grant: got %b want 0010", bus.req_ready); end
    tick();
    clear_reqs();
    tick();
    #1;
    tests++; if (bus.done_valid !== 1'b1 || bus.done_id !== 2'd1 || bus.done_err !== 1'b1 || bus.done_q !== 1'b0) begin
      fails++; $display("FAIL err_done: got v=%b id=%0d e=%b q=%b want 1 1 1 0",
                        bus.done_valid, bus.done_id, bus.done_err, bus.done_q);
    end
    tests++; if (bus.bank_q !== 8'h0E) begin fails++; $display("FAIL err_bank: got %h want 0E", bus.bank_q); end
    tick();
    bus.req_valid = '1;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL err_ptr: got %b want 0100", bus.req_ready); end
    clear_reqs();
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Starts with ptr=2, bank=0E. r2 wins and would leave ptr=3 without reset.
  task automatic test_reset_mid();
    set_req(2, 2'b10, 4'd3);
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL rmid_grant: got %b want 0100", bus.req_ready); end
    tick();  // APPLY
    clear_reqs();
    reset = 1'b1;
    tick();
    #1;
    tests++; if (bus.bank_q !== 8'h00 || bus.busy !== 1'b0 || bus.done_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_state: got bank=%h busy=%b dv=%b want 00 0 0", bus.bank_q, bus.busy, bus.done_valid);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      tests++; if (bus.done_valid !== 1'b0 || bus.bank_q !== 8'h00) begin
        fails++; $display("FAIL rmid_nodone[%0d]: got dv=%b bank=%h want 0 00", k, bus.done_valid, bus.bank_q);
      end
    end
    bus.req_valid = '1;
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL rmid_next: got %b want 0001", bus.req_ready); end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_toggle_twice();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
